// File: rtl/meter_display.sv
`default_nettype none
// meter_display: sequential binary-to-BCD converter feeding a multiplexed
// 4-digit common-anode 7-segment display with expired/low-balance blinking.
module meter_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int HALF_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] count,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        conv_done
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int HW = $clog2(HALF_DIV);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HALF_MAX    = HW'(HALF_DIV - 1);
  localparam logic [13:0]   COUNT_MAX   = 14'd9999;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [13:0] sample;
  logic [15:0] scratch;
  logic [15:0] adjusted;
  logic [29:0] shifted;
  logic [3:0]  shift_idx;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [HW-1:0] half_cnt;
  logic [1:0]    phase;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic          display_on;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = SHIFT;
      SHIFT:   if (shift_idx == 4'd13) state_next = DONE;
      DONE:    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Double-dabble: correct every nibble >= 5 before the shift so it carries as decimal.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted, sample} << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample    <= '0;
      scratch   <= '0;
      shift_idx <= '0;
      bcd       <= '0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        LOAD: begin
          sample    <= (count > COUNT_MAX) ? COUNT_MAX : count;
          scratch   <= '0;
          shift_idx <= '0;
        end
        SHIFT: begin
          scratch   <= shifted[29:14];
          sample    <= shifted[13:0];
          shift_idx <= shift_idx + 4'd1;
        end
        DONE: begin
          bcd       <= scratch;
          conv_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (digit_idx)
      2'd0:    digit = bcd[3:0];
      2'd1:    digit = bcd[7:4];
      2'd2:    digit = bcd[11:8];
      default: digit = bcd[15:12];
    endcase
    case (digit)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase
    // Expired blinks at 1 s, under 200 s at 2 s, otherwise steady.
    display_on = 1'b1;
    if (bcd == 16'h0000)     display_on = ~phase[0];
    else if (bcd < 16'h0200) display_on = ~phase[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      half_cnt    <= '0;
      phase       <= '0;
      an          <= 4'b1111;
      seg         <= 7'h7F;
    end else begin
      if (refresh_cnt == REFRESH_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      if (half_cnt == HALF_MAX) begin
        half_cnt <= '0;
        phase    <= phase + 2'd1;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
      an  <= display_on ? ~(4'b0001 << digit_idx) : 4'b1111;
      seg <= display_on ? seg_dec : 7'h7F;
    end
  end
endmodule
`default_nettype wire

// File: doc/meter_display.md
Name: meter_display

Overview:
- Display back-end for the parking meter.
- Consumes the 14-bit remaining-time count produced by the meter counter and drives a 4-digit common-anode 7-segment display.
- Performs a sequential binary-to-BCD conversion, time-multiplexes the four digits, and applies blink modes for expired and low-balance states.
- All outputs are registered.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is enabled before advancing to the next digit; minimum 2.
- HALF_DIV, 50000000, clk cycles per 0.5 s blink phase; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- count  input  14  remaining seconds from the meter counter, unsigned binary
- an  output  4  digit enables, active-low; an[0] = ones digit, an[3] = thousands digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- bcd  output  16  last converted value as 4 BCD digits, [15:12] = thousands; debug/verification tap
- conv_done  output  1  one-cycle pulse when bcd/display register updates

Behaviour:
- Reset, while rst_n=0 at a clk edge:
  - an=4'b1111, seg=7'h7F, bcd=0, conv_done=0.
  - FSM=LOAD; refresh counter, digit index and phase counter all cleared.
  - Reset mid-conversion abandons the conversion; bcd stays 0 until the first post-reset conversion completes.
- Converter FSM, free-running, states LOAD -> SHIFT -> DONE -> LOAD:
  - LOAD (1 cycle): sample count. If count>9999, clamp the sample to 9999. Clear the 16-bit scratch; shift index = 0.
  - SHIFT (14 cycles): each cycle, add 3 to every BCD nibble >=5, then shift the {scratch, sample} concatenation left by 1. Exit after the 14th shift.
  - DONE (1 cycle): copy scratch to bcd, pulse conv_done=1, return to LOAD.
- Conversion timing:
  - Period is 16 cycles.
  - A count change is reflected in bcd no later than 32 cycles after it is applied.
  - Changes to count during SHIFT are ignored until the next LOAD.
- Digit mux:
  - Refresh counter counts 0..REFRESH_DIV-1. On wrap, digit index increments 0->1->2->3->0.
  - an is one-hot low at the current index: index 0 -> 4'b1110, ..., index 3 -> 4'b0111.
  - seg carries the decode of bcd nibble[index].
  - Leading zeros are displayed, e.g. 150 shows "0150".
- Segment decode (active-low, gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Nibbles 10-15 cannot occur; decode them to blank (7'h7F).
- Blink, based on the registered bcd value (not raw count):
  - A 2-bit phase counter advances every HALF_DIV cycles, wrapping 3->0.
  - bcd==0: display on when phase[0]==0 (1 s period, 50% duty).
  - 0 < value < 200 (bcd < 16'h0200): display on when phase[1]==0 (2 s period, 50% duty).
  - value >= 200: always on.
  - When off: an=4'b1111 and seg=7'h7F. The refresh counter and digit index keep running.
  - A mode change takes effect on the next cycle after bcd updates; the phase counter is not reset on mode change.
- Output latency: an and seg are registered one cycle after the index/blink/bcd state that produced them.

Test Plan (bench uses REFRESH_DIV=4, HALF_DIV=16):
- Reset: hold rst_n=0 for 5 cycles with count=1234 -> an=4'b1111, seg=7'h7F, bcd=0. Release -> first conv_done within 17 cycles, bcd=16'h1234.
- Conversion sweep: count = 0, 9, 10, 99, 1000, 9999 -> bcd = 0000, 0009, 0010, 0099, 1000, 9999 respectively, each within 32 cycles. count=14'h3FFF -> bcd=16'h9999 (clamp).
- Mux: count=4321, steady -> an cycles 1110/1101/1011/0111 every 4 cycles with seg = 7'h79, 7'h24, 7'h30, 7'h19; display never blanks.
- Expired blink: count=0 -> digits "0000" shown for 16 cycles, blank (an=1111) for 16 cycles, repeating.
- Low blink: count=150 -> shows "0150" for 32 cycles, blank for 32 cycles. count=199 blinks; count=200 is steady on.
- Reset mid-SHIFT: assert rst_n=0 for one cycle 5 cycles after a LOAD -> bcd=0 and outputs blank. After release, a full 16-cycle conversion completes with the correct value and no stale partial result.
